// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: FSM states,
// RV32I opcode constants, ALU operation codes, immediate formats and the
// decoded-instruction bundle passed from ctrl_decode to the sequencer.
package ctrl_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Instruction classes recognised by the decoder
  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_I    = 3'd2,
    CLS_LW   = 3'd3,
    CLS_SW   = 3'd4,
    CLS_BR   = 3'd5
  } iclass_t;

  // Major opcodes (IR[6:0])
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  // Immediate format selects
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // Decoded instruction bundle
  typedef struct packed {
    iclass_t    cls;
    logic [3:0] alu_op;
    logic       cin;
    logic       alu_src;
    logic [1:0] immsel;
    logic       mux_wb;
    logic       legal;
  } dec_t;

  // Map funct3 (plus the funct7[5] alternate bit) onto an ALU code.
  // Callers are responsible for rejecting funct3 values that have no
  // supported meaning (SLTU/SLTIU) before trusting the result.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic       alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational RV32I-subset decoder: instruction word in, control
// bundle out. Anything outside the supported subset comes back with
// legal=0 and all control fields cleared.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] i_ir,
  output dec_t        o_dec
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_f7b5;
  logic       w_unused_bits;

  assign w_opcode      = i_ir[6:0];
  assign w_funct3      = i_ir[14:12];
  assign w_f7b5        = i_ir[30];
  assign w_unused_bits = ^{i_ir[31], i_ir[29:15], i_ir[11:7]};

  // Classify the opcode and derive ALU / operand / immediate controls
  always_comb begin
    o_dec         = '0;
    o_dec.cls     = CLS_NONE;
    o_dec.alu_op  = ALU_ADD;
    o_dec.immsel  = IMM_I;
    case (w_opcode)
      OP_R: begin
        // SLTU is not supported; the alternate form only exists for SUB/SRA
        if ((w_funct3 != 3'b011) &&
            (!w_f7b5 || (w_funct3 == 3'b000) || (w_funct3 == 3'b101))) begin
          o_dec.legal   = 1'b1;
          o_dec.cls     = CLS_R;
          o_dec.alu_op  = alu_from_funct3(w_funct3, w_f7b5);
          o_dec.cin     = (w_funct3 == 3'b010) || (w_f7b5 && (w_funct3 == 3'b000));
          o_dec.alu_src = 1'b0;
          o_dec.mux_wb  = 1'b1;
        end
      end
      OP_I: begin
        // No SUBI exists, so funct7[5] only matters for the SRAI shift
        if (w_funct3 != 3'b011) begin
          o_dec.legal   = 1'b1;
          o_dec.cls     = CLS_I;
          o_dec.alu_op  = alu_from_funct3(w_funct3, w_f7b5 && (w_funct3 == 3'b101));
          o_dec.cin     = (w_funct3 == 3'b010);
          o_dec.alu_src = 1'b1;
          o_dec.immsel  = IMM_I;
          o_dec.mux_wb  = 1'b1;
        end
      end
      OP_LW: begin
        if (w_funct3 == 3'b010) begin
          o_dec.legal   = 1'b1;
          o_dec.cls     = CLS_LW;
          o_dec.alu_op  = ALU_ADD;
          o_dec.alu_src = 1'b1;
          o_dec.immsel  = IMM_I;
          o_dec.mux_wb  = 1'b0;
        end
      end
      OP_SW: begin
        if (w_funct3 == 3'b010) begin
          o_dec.legal   = 1'b1;
          o_dec.cls     = CLS_SW;
          o_dec.alu_op  = ALU_ADD;
          o_dec.alu_src = 1'b1;
          o_dec.immsel  = IMM_S;
        end
      end
      OP_BR: begin
        // Only BEQ/BNE; both compare via a subtract so Z is meaningful
        if ((w_funct3 == 3'b000) || (w_funct3 == 3'b001)) begin
          o_dec.legal   = 1'b1;
          o_dec.cls     = CLS_BR;
          o_dec.alu_op  = ALU_SUB;
          o_dec.cin     = 1'b1;
          o_dec.alu_src = 1'b0;
          o_dec.immsel  = IMM_B;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit driving the datapath
// control inputs. Holds the instruction register, the retired counter and
// the sticky illegal-instruction flag.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [31:0]      Instr,
  input  logic [3:0]       Status,
  output logic             PCEn,
  output logic             PCSrc,
  output logic             ALUSrc,
  output logic [3:0]       ALUOp,
  output logic             Cin,
  output logic [1:0]       immsel,
  output logic             RamEn,
  output logic             RamWR,
  output logic             MuxWB,
  output logic             RegWrite,
  output logic             Illegal,
  output logic [CNT_W-1:0] Retired
);

  state_t           r_state;
  logic [31:0]      r_ir;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;
  logic             r_pcen;
  logic             r_alusrc;
  logic [3:0]       r_aluop;
  logic             r_cin;
  logic [1:0]       r_immsel;
  logic             r_ramen;
  logic             r_ramwr;
  logic             r_muxwb;
  logic             r_regwrite;
  logic             r_br_exec;

  logic [31:0]      w_dec_in;
  dec_t             w_dec;
  logic             w_taken;
  logic             w_unused_status;

  // While in FETCH the decoder looks at the incoming word so that the held
  // ALU controls are already valid during DECODE; afterwards it uses IR.
  assign w_dec_in = (r_state == FETCH) ? Instr : r_ir;

  ctrl_decode u_decode (
    .i_ir  (w_dec_in),
    .o_dec (w_dec)
  );

  // BEQ takes on Z, BNE (funct3[0]=1) on ~Z
  assign w_taken         = r_ir[12] ? ~Status[2] : Status[2];
  assign w_unused_status = ^{Status[3], Status[1:0]};

  assign PCEn     = r_pcen;
  assign PCSrc    = r_br_exec & w_taken;
  assign ALUSrc   = r_alusrc;
  assign ALUOp    = r_aluop;
  assign Cin      = r_cin;
  assign immsel   = r_immsel;
  assign RamEn    = r_ramen;
  assign RamWR    = r_ramwr;
  assign MuxWB    = r_muxwb;
  assign RegWrite = r_regwrite;
  assign Illegal  = r_illegal;
  assign Retired  = r_retired;

  // Retired count advances once per PC update and wraps silently
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_retired <= '0;
    end else if (r_pcen) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Sequencer FSM; every control output is registered for the state being entered
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= FETCH;
      r_ir       <= '0;
      r_illegal  <= 1'b0;
      r_pcen     <= 1'b0;
      r_alusrc   <= 1'b0;
      r_aluop    <= '0;
      r_cin      <= 1'b0;
      r_immsel   <= '0;
      r_ramen    <= 1'b0;
      r_ramwr    <= 1'b0;
      r_muxwb    <= 1'b0;
      r_regwrite <= 1'b0;
      r_br_exec  <= 1'b0;
    end else begin
      // Single-state strobes default low; ALU controls hold unless changed
      r_pcen     <= 1'b0;
      r_ramen    <= 1'b0;
      r_ramwr    <= 1'b0;
      r_muxwb    <= 1'b0;
      r_regwrite <= 1'b0;
      r_br_exec  <= 1'b0;
      case (r_state)
        FETCH: begin
          if (Run) begin
            r_ir    <= Instr;
            r_state <= DECODE;
            // Illegal words leave the held controls at zero on the way to HALT
            if (w_dec.legal) begin
              r_alusrc <= w_dec.alu_src;
              r_aluop  <= w_dec.alu_op;
              r_cin    <= w_dec.cin;
              r_immsel <= w_dec.immsel;
            end
          end
        end
        DECODE: begin
          if (!w_dec.legal) begin
            r_state   <= HALT;
            r_illegal <= 1'b1;
          end else begin
            r_state <= EXEC;
            if (w_dec.cls == CLS_BR) begin
              r_pcen    <= 1'b1;
              r_br_exec <= 1'b1;
            end
          end
        end
        EXEC: begin
          case (w_dec.cls)
            CLS_BR: begin
              r_state  <= FETCH;
              r_alusrc <= 1'b0;
              r_aluop  <= '0;
              r_cin    <= 1'b0;
              r_immsel <= '0;
            end
            CLS_LW, CLS_SW: begin
              r_state <= MEM;
              r_ramen <= 1'b1;
              r_ramwr <= (w_dec.cls == CLS_SW);
              r_pcen  <= (w_dec.cls == CLS_SW);
            end
            default: begin
              r_state    <= WB;
              r_regwrite <= 1'b1;
              r_muxwb    <= w_dec.mux_wb;
              r_pcen     <= 1'b1;
            end
          endcase
        end
        MEM: begin
          if (w_dec.cls == CLS_SW) begin
            r_state  <= FETCH;
            r_alusrc <= 1'b0;
            r_aluop  <= '0;
            r_cin    <= 1'b0;
            r_immsel <= '0;
          end else begin
            // Falling-edge RAM has the load data ready by WB
            r_state    <= WB;
            r_regwrite <= 1'b1;
            r_muxwb    <= 1'b0;
            r_pcen     <= 1'b1;
          end
        end
        WB: begin
          r_state  <= FETCH;
          r_alusrc <= 1'b0;
          r_aluop  <= '0;
          r_cin    <= 1'b0;
          r_immsel <= '0;
        end
        HALT: begin
          // Only reset leaves HALT
          r_state  <= HALT;
          r_alusrc <= 1'b0;
          r_aluop  <= '0;
          r_cin    <= 1'b0;
          r_immsel <= '0;
        end
        default: begin
          r_state  <= FETCH;
          r_alusrc <= 1'b0;
          r_aluop  <= '0;
          r_cin    <= 1'b0;
          r_immsel <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected per-cycle control vectors
// are queued before each instruction and popped as the DUT steps through it.
module tb_control_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Run = 1'b0;
  logic [31:0] Instr = '0;
  logic [3:0]  Status = '0;

  logic        PCEn, PCSrc, ALUSrc, Cin, RamEn, RamWR, MuxWB, RegWrite, Illegal;
  logic [3:0]  ALUOp;
  logic [1:0]  immsel;
  logic [15:0] Retired;

  logic        PCEn2, PCSrc2, ALUSrc2, Cin2, RamEn2, RamWR2, MuxWB2, RegWrite2, Illegal2;
  logic [3:0]  ALUOp2;
  logic [1:0]  immsel2;
  logic [1:0]  Retired2;

  control_sequencer #(.CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Instr(Instr), .Status(Status),
    .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .Cin(Cin),
    .immsel(immsel), .RamEn(RamEn), .RamWR(RamWR), .MuxWB(MuxWB),
    .RegWrite(RegWrite), .Illegal(Illegal), .Retired(Retired)
  );

  // Narrow-counter copy used only to observe wrap-around
  control_sequencer #(.CNT_W(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Instr(Instr), .Status(Status),
    .PCEn(PCEn2), .PCSrc(PCSrc2), .ALUSrc(ALUSrc2), .ALUOp(ALUOp2), .Cin(Cin2),
    .immsel(immsel2), .RamEn(RamEn2), .RamWR(RamWR2), .MuxWB(MuxWB2),
    .RegWrite(RegWrite2), .Illegal(Illegal2), .Retired(Retired2)
  );

  always #5 Clk = ~Clk;

  logic [14:0] obs;
  assign obs = {PCEn, PCSrc, ALUSrc, ALUOp, Cin, immsel, RamEn, RamWR, MuxWB, RegWrite};

  logic [14:0] q[$];
  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  function automatic logic [14:0] vec(input logic pcen, input logic pcsrc,
                                      input logic alusrc, input logic [3:0] aluop,
                                      input logic cin, input logic [1:0] imm,
                                      input logic ramen, input logic ramwr,
                                      input logic muxwb, input logic regwrite);
    return {pcen, pcsrc, alusrc, aluop, cin, imm, ramen, ramwr, muxwb, regwrite};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic pop_chk(input string tag);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s observed=queue-empty expected=entry", tag);
    end else begin
      chk(tag, 32'(obs), 32'(q.pop_front()));
    end
  endtask

  // Launch one instruction from FETCH and compare nc cycles of controls
  task automatic run_instr(input string tag, input logic [31:0] ins,
                           input logic [3:0] st, input int nc);
    Instr = ins;
    Status = st;
    Run = 1'b1;
    #1;
    for (int c = 0; c < nc; c++) begin
      pop_chk($sformatf("%s c%0d", tag, c));
      @(posedge Clk);
      #1 Run = 1'b0;
      @(negedge Clk);
      #1;
    end
    exp_ret++;
    chk({tag, " Retired"}, 32'(Retired), 32'(exp_ret % 65536));
    chk({tag, " Retired2"}, 32'(Retired2), 32'(exp_ret % 4));
    $display("txn %s instr=%h status=%b retired=%0d retired2=%0d",
             tag, ins, st, Retired, Retired2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge Clk);
    #1;
    chk("reset ctrl", 32'(obs), 32'h0);
    chk("reset Illegal", 32'(Illegal), 32'h0);
    chk("reset Retired", 32'(Retired), 32'h0);
    chk("reset Retired2", 32'(Retired2), 32'h0);
    $display("txn reset ctrl=%h illegal=%b retired=%0d", obs, Illegal, Retired);
    Reset = 1'b1;

    // ADD aborted by reset during WB
    q.push_back(15'h0);
    q.push_back(vec(0,0,0,4'b0000,0,2'b00,0,0,0,0));
    q.push_back(vec(0,0,0,4'b0000,0,2'b00,0,0,0,0));
    q.push_back(vec(1,0,0,4'b0000,0,2'b00,0,0,1,1));
    Instr = 32'h002081B3;
    Status = 4'h0;
    Run = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      pop_chk($sformatf("ADDabort c%0d", c));
      if (c < 3) begin
        @(posedge Clk);
        #1 Run = 1'b0;
        @(negedge Clk);
        #1;
      end
    end
    Reset = 1'b0;
    #1;
    chk("abort ctrl", 32'(obs), 32'h0);
    chk("abort Retired", 32'(Retired), 32'h0);
    $display("txn ADDabort ctrl=%h retired=%0d", obs, Retired);
    @(negedge Clk);
    Reset = 1'b1;
    #1;

    // ADD x3,x1,x2
    q.push_back(15'h0);
    q.push_back(vec(0,0,0,4'b0000,0,2'b00,0,0,0,0));
    q.push_back(vec(0,0,0,4'b0000,0,2'b00,0,0,0,0));
    q.push_back(vec(1,0,0,4'b0000,0,2'b00,0,0,1,1));
    run_instr("ADD", 32'h002081B3, 4'h0, 4);

    // Run low: sequencer idles in FETCH
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      #1;
      chk($sformatf("idle c%0d ctrl", c), 32'(obs), 32'h0);
    end
    chk("idle Retired", 32'(Retired), 32'(exp_ret));

    // LW x5,8(x0)
    q.push_back(15'h0);
    q.push_back(vec(0,0,1,4'b0000,0,2'b00,0,0,0,0));
    q.push_back(vec(0,0,1,4'b0000,0,2'b00,0,0,0,0));
    q.push_back(vec(0,0,1,4'b0000,0,2'b00,1,0,0,0));
    q.push_back(vec(1,0,1,4'b0000,0,2'b00,0,0,0,1));
    run_instr("LW", 32'h00802283, 4'h0, 5);

    // SW x5,4(x0)
    q.push_back(15'h0);
    q.push_back(vec(0,0,1,4'b0000,0,2'b01,0,0,0,0));
    q.push_back(vec(0,0,1,4'b0000,0,2'b01,0,0,0,0));
    q.push_back(vec(1,0,1,4'b0000,0,2'b01,1,1,0,0));
    run_instr("SW", 32'h00502223, 4'h0, 4);

    // BEQ taken (Z=1); fourth retirement wraps the 2-bit counter
    q.push_back(15'h0);
    q.push_back(vec(0,0,0,4'b0001,1,2'b10,0,0,0,0));
    q.push_back(vec(1,1,0,4'b0001,1,2'b10,0,0,0,0));
    run_instr("BEQ_Z", 32'h00000463, 4'b0100, 3);

    // BEQ not taken
    q.push_back(15'h0);
    q.push_back(vec(0,0,0,4'b0001,1,2'b10,0,0,0,0));
    q.push_back(vec(1,0,0,4'b0001,1,2'b10,0,0,0,0));
    run_instr("BEQ_NZ", 32'h00000463, 4'b0000, 3);

    // BNE taken (Z=0)
    q.push_back(15'h0);
    q.push_back(vec(0,0,0,4'b0001,1,2'b10,0,0,0,0));
    q.push_back(vec(1,1,0,4'b0001,1,2'b10,0,0,0,0));
    run_instr("BNE_NZ", 32'h00001463, 4'b0000, 3);

    // BNE not taken (Z=1)
    q.push_back(15'h0);
    q.push_back(vec(0,0,0,4'b0001,1,2'b10,0,0,0,0));
    q.push_back(vec(1,0,0,4'b0001,1,2'b10,0,0,0,0));
    run_instr("BNE_Z", 32'h00001463, 4'b0100, 3);

    // Illegal opcode: HALT, sticky flag, no PCEn even with Run held high
    q.push_back(15'h0);
    q.push_back(15'h0);
    Instr = 32'h0000007F;
    Status = 4'h0;
    Run = 1'b1;
    #1;
    pop_chk("ILL fetch");
    @(posedge Clk);
    @(negedge Clk);
    #1;
    pop_chk("ILL decode");
    for (int c = 0; c < 20; c++) begin
      @(posedge Clk);
      @(negedge Clk);
      #1;
      chk($sformatf("HALT c%0d Illegal", c), 32'(Illegal), 32'h1);
      chk($sformatf("HALT c%0d ctrl", c), 32'(obs), 32'h0);
    end
    chk("HALT Retired", 32'(Retired), 32'(exp_ret));
    $display("txn ILL instr=0000007f illegal=%b retired=%0d", Illegal, Retired);
    Run = 1'b0;
    Reset = 1'b0;
    #1;
    chk("ILL reset Illegal", 32'(Illegal), 32'h0);
    chk("ILL reset Retired", 32'(Retired), 32'h0);
    exp_ret = 0;
    @(negedge Clk);
    Reset = 1'b1;
    #1;

    // Back in FETCH: a fresh ADD runs normally
    q.push_back(15'h0);
    q.push_back(vec(0,0,0,4'b0000,0,2'b00,0,0,0,0));
    q.push_back(vec(0,0,0,4'b0000,0,2'b00,0,0,0,0));
    q.push_back(vec(1,0,0,4'b0000,0,2'b00,0,0,1,1));
    run_instr("ADD_after_halt", 32'h002081B3, 4'h0, 4);

    chk("queue drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
